fir_seq_queue: RTL and testbench
================================

# fir_seq_queue

Stereo sample queue and sequencer that feeds one FIR band filter (ROM-coefficient, serial multiply-accumulate type). It stores the last DEPTH stereo samples in a circular buffer. On every new sample, once the buffer is full, it asserts `sequencing` and streams the DEPTH stored samples oldest-first, one per cycle, so the filter produces a fresh output. One instance sits in front of each band filter, between the sample-rate input strobe and the filter.

## Interface
- DEPTH, 1021, number of stored samples and filter taps (must be ≥ 2 and ≤ 2^AW)
- AW, 10, buffer address width
- clk  in  1  system clock, all flops on posedge
- rst_n  in  1  asynchronous active-low reset
- smp_vld  in  1  one-cycle strobe: new stereo sample present on lft_smp/rght_smp
- lft_smp  in  16  signed left sample
- rght_smp  in  16  signed right sample
- sequencing  out  1  registered; high for exactly DEPTH+1 consecutive cycles per sequence
- lft_q  out  16  signed left sample streamed to filter, registered buffer read
- rght_q  out  16  signed right sample streamed to filter
- seq_done  out  1  one-cycle pulse the cycle after sequencing falls (filter output valid)
- full  out  1  buffer holds DEPTH samples
- ovr_cnt  out  8  overrun count (present only with SEQ_OVR_CNT_EN)

## Operation
- States: FILL, WAIT, SEQ (shared enum).
- FILL: each smp_vld writes at wr_ptr; wr_ptr and cnt increment. When cnt reaches DEPTH, set full and go to WAIT. The write that fills the buffer does not start a sequence.
- WAIT: smp_vld overwrites the oldest entry (at wr_ptr), advances wr_ptr, sets rd_ptr = new oldest (= new wr_ptr), then enters SEQ.
- SEQ: rd_ptr advances each cycle, DEPTH reads total, oldest to newest. Then return to WAIT; if a sample is pending, perform its write and re-enter SEQ immediately.
- Pointer wrap: DEPTH-1 → 0. DEPTH need not be a power of two.
- smp_vld during SEQ: sample latched in hold register, pending set, no buffer write during SEQ.
- Second smp_vld while pending: newer sample dropped, hold unchanged, overrun event.
- smp_vld in the final SEQ cycle counts as during SEQ.
- lft_q/rght_q hold their last value outside SEQ.

## Timing
- smp_vld sampled at edge T (WAIT) → write at edge T; sequencing = 1 in cycles T+1 … T+1+DEPTH.
- lft_q/rght_q in cycle T+2+k = stored sample k (k = 0 oldest … DEPTH-1 newest). This gives one-cycle read latency, aligned to a filter that clears its accumulator on the first sequencing cycle and accumulates on the next DEPTH cycles.
- seq_done = 1 in cycle T+2+DEPTH.
- Pending sample: its write occurs on the cycle sequencing is low, and the next sequencing rises on the following cycle. Minimum gap is one low cycle between sequences.
- Reset (any time, including mid-SEQ): sequencing, seq_done, full, pending = 0; lft_q, rght_q = 0; cnt, pointers = 0; ovr_cnt = 0; state FILL. Buffer contents are don't-care; a full refill is required.

## Configuration
- SEQ_OVR_CNT_EN defined: ovr_cnt port exists. It increments on each dropped sample and saturates at 255. Reset clears it.
- Undefined: no ovr_cnt port or counter. Dropped samples are silent; all other behaviour is identical.

## Structure
- Shared package `eq_pkg`: seq_state_t enum (FILL, WAIT, SEQ), SMP_W = 16, default DEPTH values per band.
- Sub-module `seq_dpram`: simple dual-port RAM, 32-bit wide ({lft, rght}), DEPTH entries, one write port, one registered read port, no reset on the array.
- Top holds the FSM, pointers, cnt, hold register and output registers.

## Test plan
- DEPTH = 4. Write 1, 2, 3, 4 → full = 1 after the 4th, sequencing stays 0. Write 5 → sequencing high 5 cycles, lft_q = 2, 3, 4, 5 on the last 4 of them, seq_done 1 cycle later.
- Wrap: DEPTH = 5, write 1 … 12 with spacing of 10 cycles → the final sequence streams 8, 9, 10, 11, 12. Right channel uses negated values, expect -8 … -12.
- Pending: DEPTH = 4, full; smp_vld in the 2nd SEQ cycle with value 9 → after the current sequence ends, one low cycle, then a new sequence ending with lft_q = 9.
- Overrun (SEQ_OVR_CNT_EN): two strobes during one SEQ → second dropped, ovr_cnt = 1. 300 overruns → ovr_cnt = 255.
- Reset mid-SEQ: assert rst_n low at cycle 3 of SEQ → all outputs 0 immediately. After release, 3 writes produce no sequencing, and full = 0.
- Filter integration: DEPTH = 4, FIR ROM = {1, 1, 1, 1} (Q15 0x7FFF), samples 1000 → filter output ≈ sum of the four stored samples, captured on seq_done.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types and constants for the equaliser band-filter front ends.
package eq_pkg;

   typedef enum logic [1:0] {FILL, WAIT, SEQ} seq_state_t;

   localparam int SMP_W = 16;

   // Default tap count per band: low bands need the longest filters
   function automatic int band_depth(input int band);
      case (band)
         0:       return 1021;
         1:       return 511;
         default: return 255;
      endcase
   endfunction

endpackage

// File: rtl/fir_seq_queue_if.sv
// Sample-in / stream-out bundle between the sample source, fir_seq_queue and its filter.
// Optional macro SEQ_OVR_CNT_EN adds the ovr_cnt overrun counter.
interface fir_seq_queue_if;
   import eq_pkg::*;

   logic                    smp_vld;
   logic signed [SMP_W-1:0] lft_smp;
   logic signed [SMP_W-1:0] rght_smp;
   logic                    sequencing;
   logic signed [SMP_W-1:0] lft_q;
   logic signed [SMP_W-1:0] rght_q;
   logic                    seq_done;
   logic                    full;
`ifdef SEQ_OVR_CNT_EN
   logic [7:0]              ovr_cnt;

   modport master (output smp_vld, lft_smp, rght_smp,
                   input  sequencing, lft_q, rght_q, seq_done, full, ovr_cnt);
   modport slave  (input  smp_vld, lft_smp, rght_smp,
                   output sequencing, lft_q, rght_q, seq_done, full, ovr_cnt);
`else
   modport master (output smp_vld, lft_smp, rght_smp,
                   input  sequencing, lft_q, rght_q, seq_done, full);
   modport slave  (input  smp_vld, lft_smp, rght_smp,
                   output sequencing, lft_q, rght_q, seq_done, full);
`endif

endinterface

// File: rtl/seq_dpram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The array is not reset; only the read register clears.
module seq_dpram #(
   parameter int DEPTH = 1021,
   parameter int AW    = 10,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fir_seq_queue.sv
// Stereo sample queue and sequencer feeding one serial-MAC FIR band filter.
// Optional macro SEQ_OVR_CNT_EN enables the saturating overrun counter.
module fir_seq_queue
   import eq_pkg::*;
#(
   parameter int DEPTH = band_depth(0),
   parameter int AW    = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   fir_seq_queue_if.slave bus
);

   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
   localparam logic [AW:0]   CNT_LAST = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0]   RD_DONE  = (AW+1)'(DEPTH);

   seq_state_t              state, next_state;
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic [AW:0]             cnt, rd_cnt;
   logic                    pending;
   logic signed [SMP_W-1:0] hold_lft, hold_rght;
   logic signed [SMP_W-1:0] wr_lft, wr_rght;
   logic                    wr_en, rd_en, latch, drop, use_hold;
   logic [2*SMP_W-1:0]      rd_word;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      next_state = state;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      latch      = 1'b0;
      drop       = 1'b0;
      use_hold   = 1'b0;
      case (state)
         FILL: if (bus.smp_vld) begin
            wr_en = 1'b1;
            if (cnt == CNT_LAST) next_state = WAIT;
         end
         // A held sample has priority; a strobe arriving with it is the newer one and is dropped
         WAIT: if (pending) begin
            wr_en      = 1'b1;
            use_hold   = 1'b1;
            drop       = bus.smp_vld;
            next_state = SEQ;
         end else if (bus.smp_vld) begin
            wr_en      = 1'b1;
            next_state = SEQ;
         end
         // DEPTH read cycles plus one trailing cycle that presents the newest sample
         SEQ: begin
            if (rd_cnt == RD_DONE) next_state = WAIT;
            else                   rd_en      = 1'b1;
            if (bus.smp_vld) begin
               drop  = pending;
               latch = !pending;
            end
         end
         default: next_state = FILL;
      endcase
   end

   assign wr_lft  = use_hold ? hold_lft  : bus.lft_smp;
   assign wr_rght = use_hold ? hold_rght : bus.rght_smp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= FILL;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         cnt            <= '0;
         rd_cnt         <= '0;
         pending        <= 1'b0;
         bus.full       <= 1'b0;
         bus.sequencing <= 1'b0;
         bus.seq_done   <= 1'b0;
      end else begin
         state          <= next_state;
         bus.sequencing <= (next_state == SEQ);
         bus.seq_done   <= (state == SEQ) && (next_state != SEQ);
         if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
         if (state == FILL && wr_en) begin
            cnt <= cnt + (AW+1)'(1);
            if (cnt == CNT_LAST) bus.full <= 1'b1;
         end
         // Oldest entry after an overwrite is the slot just past the one written
         if (state == WAIT && wr_en) begin
            rd_ptr <= ptr_inc(wr_ptr);
            rd_cnt <= '0;
         end else if (rd_en) begin
            rd_ptr <= ptr_inc(rd_ptr);
            rd_cnt <= rd_cnt + (AW+1)'(1);
         end
         if (latch)         pending <= 1'b1;
         else if (use_hold) pending <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (latch) begin
         hold_lft  <= bus.lft_smp;
         hold_rght <= bus.rght_smp;
      end
   end

`ifdef SEQ_OVR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              bus.ovr_cnt <= '0;
      else if (drop && bus.ovr_cnt != 8'hFF)   bus.ovr_cnt <= bus.ovr_cnt + 8'd1;
   end
`else
   logic unused_drop;
   assign unused_drop = drop;
`endif

   seq_dpram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .WIDTH (2*SMP_W)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata ({wr_lft, wr_rght}),
      .re    (rd_en),
      .raddr (rd_ptr),
      .rdata (rd_word)
   );

   assign bus.lft_q  = rd_word[2*SMP_W-1:SMP_W];
   assign bus.rght_q = rd_word[SMP_W-1:0];

endmodule

// File: tb/tb_fir_seq_queue.sv
// Randomized bench for fir_seq_queue against a time-line reference model of the sequencer.
// Overrun counter is checked when SEQ_OVR_CNT_EN is defined.
module tb_fir_seq_queue;

   localparam int DEPTH = 5;
   localparam int AW    = 3;
   localparam int NC    = 2048;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   fir_seq_queue_if bus ();

   fir_seq_queue #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: stored window, pending sample and a per-cycle expectation timeline
   logic signed [15:0] st_l[$];
   logic signed [15:0] st_r[$];
   bit                 pend;
   logic signed [15:0] pend_l, pend_r;
   int                 seq_end;
   int                 last_start;
   bit                 m_full;
   int                 m_ovr;
   logic signed [15:0] exp_l, exp_r;
   bit                 exp_seq  [NC];
   bit                 exp_done [NC];
   bit                 q_set    [NC];
   logic signed [15:0] q_l      [NC];
   logic signed [15:0] q_r      [NC];

   task automatic check_eq(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, act, exp);
      end
   endtask

   function automatic void model_reset();
      st_l.delete();
      st_r.delete();
      pend       = 1'b0;
      seq_end    = -1;
      last_start = -100;
      m_full     = 1'b0;
      m_ovr      = 0;
      exp_l      = '0;
      exp_r      = '0;
      cyc        = 0;
      for (int i = 0; i < NC; i++) begin
         exp_seq[i]  = 1'b0;
         exp_done[i] = 1'b0;
         q_set[i]    = 1'b0;
      end
   endfunction

   function automatic void bump_ovr();
      if (m_ovr < 255) m_ovr++;
   endfunction

   // New sample written in cycle c: window slides, outputs stream oldest-first from c+2
   function automatic void start_seq(input logic signed [15:0] l, input logic signed [15:0] r);
      st_l.push_back(l);
      st_r.push_back(r);
      void'(st_l.pop_front());
      void'(st_r.pop_front());
      for (int k = 1; k <= DEPTH + 1; k++)
         if (cyc + k < NC) exp_seq[cyc + k] = 1'b1;
      for (int k = 0; k < DEPTH; k++)
         if (cyc + 2 + k < NC) begin
            q_set[cyc + 2 + k] = 1'b1;
            q_l[cyc + 2 + k]   = st_l[k];
            q_r[cyc + 2 + k]   = st_r[k];
         end
      if (cyc + 2 + DEPTH < NC) exp_done[cyc + 2 + DEPTH] = 1'b1;
      seq_end    = cyc + 1 + DEPTH;
      last_start = cyc;
   endfunction

   function automatic void model_cycle(input bit vld, input logic signed [15:0] l,
                                       input logic signed [15:0] r);
      if (st_l.size() < DEPTH) begin
         if (vld) begin
            st_l.push_back(l);
            st_r.push_back(r);
         end
         if (st_l.size() == DEPTH) m_full = 1'b1;
      end else if (cyc <= seq_end) begin
         if (vld) begin
            if (pend) bump_ovr();
            else begin
               pend   = 1'b1;
               pend_l = l;
               pend_r = r;
            end
         end
      end else if (pend) begin
         pend = 1'b0;
         start_seq(pend_l, pend_r);
         if (vld) bump_ovr();
      end else if (vld) begin
         start_seq(l, r);
      end
   endfunction

   task automatic check_outputs();
      if (q_set[cyc]) begin
         exp_l = q_l[cyc];
         exp_r = q_r[cyc];
      end
      check_eq("sequencing", int'(bus.sequencing), int'(exp_seq[cyc]));
      check_eq("seq_done",   int'(bus.seq_done),   int'(exp_done[cyc]));
      check_eq("full",       int'(bus.full),       int'(m_full));
      check_eq("lft_q",      int'(bus.lft_q),      int'(exp_l));
      check_eq("rght_q",     int'(bus.rght_q),     int'(exp_r));
`ifdef SEQ_OVR_CNT_EN
      check_eq("ovr_cnt",    int'(bus.ovr_cnt),    m_ovr);
`endif
   endtask

   task automatic step(input bit vld, input logic signed [15:0] l, input logic signed [15:0] r);
      @(negedge clk);
      check_outputs();
      bus.smp_vld  = vld;
      bus.lft_smp  = l;
      bus.rght_smp = r;
      model_cycle(vld, l, r);
      cyc++;
   endtask

   task automatic step_rand(input int prob);
      bit vld;
      vld = (int'($urandom_range(99)) < prob);
      step(vld, 16'($urandom), 16'($urandom));
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_sequencing"}, int'(bus.sequencing), 0);
      check_eq({tag, "_seq_done"},   int'(bus.seq_done),   0);
      check_eq({tag, "_full"},       int'(bus.full),       0);
      check_eq({tag, "_lft_q"},      int'(bus.lft_q),      0);
      check_eq({tag, "_rght_q"},     int'(bus.rght_q),     0);
`ifdef SEQ_OVR_CNT_EN
      check_eq({tag, "_ovr_cnt"},    int'(bus.ovr_cnt),    0);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      bus.smp_vld  = 1'b0;
      bus.lft_smp  = '0;
      bus.rght_smp = '0;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      model_reset();

      // Spaced writes 1..12: wraps the non-power-of-two pointer, last window is 8..12
      for (int v = 1; v <= 12; v++) begin
         step(1'b1, 16'(v), -16'(v));
         repeat (9) step(1'b0, 16'(0), 16'(0));
      end
      repeat (300) step_rand(10);
      repeat (300) step_rand(35);
      repeat (600) step_rand(100);
      repeat (30)  step_rand(0);

      // Run until the third cycle of a sequence, then reset asynchronously mid-stream
      guard = 0;
      while (!(cyc == last_start + 3 && exp_seq[cyc]) && guard < 300) begin
         step_rand(30);
         guard++;
      end
      @(negedge clk);
      check_eq("mid_seq_active", int'(bus.sequencing), int'(exp_seq[cyc]));
      bus.smp_vld = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_zero("async_reset");
      repeat (2) @(negedge clk);
      check_zero("held_reset");
      rst_n = 1'b1;
      model_reset();

      repeat (3) begin
         step(1'b1, 16'($urandom), 16'($urandom));
         repeat (3) step(1'b0, 16'(0), 16'(0));
      end
      repeat (250) step_rand(25);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
